write_back_register_file: RTL and testbench
===========================================

# write_back_register_file

Write-back stage and register file for the 32-bit RISC pipeline; the responder to the decode/operand-fetch stage. Captures the execute-stage result into a WB pipeline register, selects the write-back value by MD, writes the 32x32 register file, and serves decode's two combinational read ports (AA to A_DATA, BA to B_DATA) with write-through bypass. Also flags read-after-write hazards against the instruction currently in execute, so the top-level pipeline control can stall decode.

## Interface
- Parameters: none (widths fixed: 32-bit data, 5-bit register address).
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- RW_EX  in  1  register-write enable of instruction in execute
- DA_EX  in  5  destination register of instruction in execute
- MD_EX  in  2  write-back source select of instruction in execute
- F_EX  in  32  function-unit result
- NxorV_EX  in  1  N xor V from function unit (set-less-than)
- DMEM_DATA  in  32  data-memory read data, valid during WB cycle
- AA, BA  in  5 each  decode read addresses
- use_A, use_B  in  1 each  decode actually consumes register operand A / B (MA=0 / MB=0)
- A_DATA, B_DATA  out  32 each  read data to decode
- stall  out  1  RAW hazard against execute stage
- RW_WB, DA_WB  out  1 / 5  registered write enable / destination (observability)
- WB_DATA  out  32  selected write-back value

## Operation
- WB register: each rising edge captures RW_EX, DA_EX, MD_EX, F_EX, NxorV_EX into RW_WB, DA_WB, MD_WB, F_WB, NxorV_WB. No enable; bubbles arrive as RW_EX=0.
- WB_DATA select by MD_WB: 00 F_WB; 01 DMEM_DATA; 10 {31'b0, NxorV_WB}; 11 reserved, drives 0.
- Write: at rising edge, if RW_WB=1 and DA_WB!=0, reg[DA_WB] <= WB_DATA.
- R0 hardwired zero: never written; reading address 0 returns 0 regardless of bypass.
- Read: A_DATA = 0 if AA=0; else WB_DATA if RW_WB and DA_WB==AA; else reg[AA]. B_DATA identical with BA.
- stall = (use_A and AA==DA_EX) or (use_B and BA==DA_EX), qualified by RW_EX=1 and DA_EX!=0. WB-stage dependencies never stall (covered by bypass).
- Reset: clears all 31 writable registers and the WB register (RW_WB=0, DA_WB=0, MD_WB=00, F_WB=0, NxorV_WB=0). Reset wins over a write pending in WB the same edge.

## Timing
- Reset values: RW_WB 0, DA_WB 0, WB_DATA 0; while reset=1, A_DATA, B_DATA and stall are forced to 0.
- Read latency 0 (combinational from AA/BA).
- Write latency: value enters WB one edge after EX, architecturally visible via bypass in that WB cycle, and in the array after the following edge.
- stall is combinational, same cycle as the decode address; no internal stall state.
- Simultaneous write and read of the same nonzero register: the read returns the new value (bypass).
- Back-to-back writes to the same register: last WB wins; bypass always reflects the current WB instruction.

## Structure
- Shared package pipe_pkg: MD_FUNC=2'b00, MD_MEM=2'b01, MD_SLT=2'b10, MD_RSVD=2'b11, REG_ZERO=5'd0, DATA_W=32, ADDR_W=5.
- One sub-module: register_array (32x32, two async read ports, one sync write port, R0 zero, synchronous clear). Bypass, MD mux, WB register and hazard logic live in the top.

## Test plan
- Reset 2 cycles, AA=5, BA=31, use_A=use_B=1 -> A_DATA=B_DATA=0, stall=0, RW_WB=0, WB_DATA=0.
- EX: RW=1, DA=3, MD=00, F=0xDEADBEEF; next cycle AA=3 -> A_DATA=0xDEADBEEF via bypass; one cycle later (RW_EX=0) still 0xDEADBEEF from the array.
- EX: RW=1, DA=0, F=0x1234; AA=0, use_A=1 -> stall=0, A_DATA=0 in every cycle.
- EX: RW=1, DA=7; AA=7, use_A=1 -> stall=1; use_A=0 -> stall=0; BA=7, use_B=1 -> stall=1; RW_EX=0 -> stall=0.
- MD=01 with DMEM_DATA=0xCAFEF00D to R9 -> R9=0xCAFEF00D; MD=10, NxorV=1 to R10 -> R10=1; MD=11, F=0xFFFF to R11 -> R11=0.
- Write R4=0x55 complete; then WB holds RW=1, DA=4, F=0xAA with reset asserted on that edge -> after release, AA=4 returns 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the write-back stage and register file.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Write-back source select encodings.
    localparam logic [1:0] MD_FUNC = 2'b00;
    localparam logic [1:0] MD_MEM  = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;
    localparam logic [1:0] MD_RSVD = 2'b11;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Contents of the WB pipeline register.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] da;
        logic [1:0]        md;
        logic [DATA_W-1:0] f;
        logic              nxorv;
    } wb_reg_t;

endpackage

// File: rtl/register_array.sv
// 32x32 register array: two asynchronous read ports, one synchronous write
// port, R0 reads as zero and is never written, synchronous clear on reset.
module register_array
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Clear everything on reset; otherwise write any register except R0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            mem[waddr] <= wdata;
        end
    end

    // Address 0 is decoded to zero rather than relying on mem[0] contents.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != REG_ZERO) rdata_a = mem[raddr_a];
        if (raddr_b != REG_ZERO) rdata_b = mem[raddr_b];
    end

endmodule

// File: rtl/write_back_register_file.sv
// Write-back stage plus register file: WB pipeline register, write-back
// source mux, register array with write-through bypass, and RAW hazard
// detection against the instruction currently in execute.
module write_back_register_file
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RW_EX,
    input  logic [ADDR_W-1:0] DA_EX,
    input  logic [1:0]        MD_EX,
    input  logic [DATA_W-1:0] F_EX,
    input  logic              NxorV_EX,
    input  logic [DATA_W-1:0] DMEM_DATA,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              use_A,
    input  logic              use_B,
    output logic [DATA_W-1:0] A_DATA,
    output logic [DATA_W-1:0] B_DATA,
    output logic              stall,
    output logic              RW_WB,
    output logic [ADDR_W-1:0] DA_WB,
    output logic [DATA_W-1:0] WB_DATA
);

    wb_reg_t           wb_q;
    logic              wb_we;
    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;

    // WB pipeline register: unconditional capture, bubbles arrive as RW_EX=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q.rw    <= RW_EX;
            wb_q.da    <= DA_EX;
            wb_q.md    <= MD_EX;
            wb_q.f     <= F_EX;
            wb_q.nxorv <= NxorV_EX;
        end
    end

    // Select the write-back value; the reserved encoding drives zero.
    always_comb begin
        WB_DATA = '0;
        case (wb_q.md)
            MD_FUNC: WB_DATA = wb_q.f;
            MD_MEM:  WB_DATA = DMEM_DATA;
            MD_SLT:  WB_DATA = {{(DATA_W-1){1'b0}}, wb_q.nxorv};
            MD_RSVD: WB_DATA = '0;
            default: WB_DATA = '0;
        endcase
    end

    assign RW_WB = wb_q.rw;
    assign DA_WB = wb_q.da;
    assign wb_we = wb_q.rw && (wb_q.da != REG_ZERO);

    register_array u_register_array (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_q.da),
        .wdata   (WB_DATA),
        .raddr_a (AA),
        .raddr_b (BA),
        .rdata_a (arr_a),
        .rdata_b (arr_b)
    );

    // Read ports: R0 is zero, then bypass from WB, then the array.
    // Outputs are held at zero while reset is asserted.
    always_comb begin
        A_DATA = '0;
        B_DATA = '0;
        if (!reset) begin
            if (AA == REG_ZERO)                A_DATA = '0;
            else if (wb_we && (wb_q.da == AA)) A_DATA = WB_DATA;
            else                               A_DATA = arr_a;
            if (BA == REG_ZERO)                B_DATA = '0;
            else if (wb_we && (wb_q.da == BA)) B_DATA = WB_DATA;
            else                               B_DATA = arr_b;
        end
    end

    // RAW hazard against execute only; WB-stage dependencies are bypassed.
    always_comb begin
        stall = 1'b0;
        if (!reset && RW_EX && (DA_EX != REG_ZERO)) begin
            stall = (use_A && (AA == DA_EX)) || (use_B && (BA == DA_EX));
        end
    end

endmodule

// File: tb/tb_write_back_register_file.sv
// Self-checking bench for write_back_register_file: directed steps from the
// feature list followed by randomized traffic, all checked against an
// architectural model (register array plus the instruction sitting in WB).
module tb_write_back_register_file;
    import pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        RW_EX;
    logic [4:0]  DA_EX;
    logic [1:0]  MD_EX;
    logic [31:0] F_EX;
    logic        NxorV_EX;
    logic [31:0] DMEM_DATA;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        use_A;
    logic        use_B;
    logic [31:0] A_DATA;
    logic [31:0] B_DATA;
    logic        stall;
    logic        RW_WB;
    logic [4:0]  DA_WB;
    logic [31:0] WB_DATA;

    int vectors    = 0;
    int miscompares = 0;

    write_back_register_file dut (
        .clk       (clk),
        .reset     (reset),
        .RW_EX     (RW_EX),
        .DA_EX     (DA_EX),
        .MD_EX     (MD_EX),
        .F_EX      (F_EX),
        .NxorV_EX  (NxorV_EX),
        .DMEM_DATA (DMEM_DATA),
        .AA        (AA),
        .BA        (BA),
        .use_A     (use_A),
        .use_B     (use_B),
        .A_DATA    (A_DATA),
        .B_DATA    (B_DATA),
        .stall     (stall),
        .RW_WB     (RW_WB),
        .DA_WB     (DA_WB),
        .WB_DATA   (WB_DATA)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural registers plus the instruction in WB.
    // wb_q holds at most one entry; empty means a bubble.
    typedef struct {
        bit          rw;
        int          da;
        int          md;
        logic [31:0] f;
        bit          nv;
    } instr_t;

    logic [31:0] m_regs [32];
    instr_t      wb_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] m_wb_value();
        if (wb_q.size() == 0) return 32'd0;
        if (wb_q[0].md == 0) return wb_q[0].f;
        if (wb_q[0].md == 1) return DMEM_DATA;
        if (wb_q[0].md == 2) return wb_q[0].nv ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input int addr);
        if (reset || addr == 0) return 32'd0;
        if (wb_q.size() != 0 && wb_q[0].rw && wb_q[0].da == addr) return m_wb_value();
        return m_regs[addr];
    endfunction

    function automatic bit m_stall();
        if (reset || !RW_EX || DA_EX == 0) return 1'b0;
        return (use_A && AA == DA_EX) || (use_B && BA == DA_EX);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Driver: apply one cycle's inputs after the falling edge, then check.
    task automatic drive(input bit rst, input bit rw, input int da, input int md,
                         input logic [31:0] f, input bit nv, input logic [31:0] dmem,
                         input int aa, input int ba, input bit ua, input bit ub);
        reset = rst; RW_EX = rw; DA_EX = 5'(da); MD_EX = 2'(md); F_EX = f;
        NxorV_EX = nv; DMEM_DATA = dmem; AA = 5'(aa); BA = 5'(ba);
        use_A = ua; use_B = ub;
        #1;
        chk("a_data",  A_DATA,  m_read(aa));
        chk("b_data",  B_DATA,  m_read(ba));
        chk("stall",   {31'd0, stall}, {31'd0, m_stall()});
        chk("rw_wb",   {31'd0, RW_WB}, (wb_q.size() != 0 && wb_q[0].rw) ? 32'd1 : 32'd0);
        chk("da_wb",   {27'd0, DA_WB}, (wb_q.size() != 0) ? 32'(wb_q[0].da) : 32'd0);
        chk("wb_data", WB_DATA, m_wb_value());
    endtask

    // Advance one rising edge and update the model the same way.
    task automatic tick();
        instr_t nx;
        logic [31:0] val;
        val = m_wb_value();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            wb_q.delete();
            exp_q.delete();
        end else begin
            if (wb_q.size() != 0) begin
                if (wb_q[0].rw && wb_q[0].da != 0) begin
                    m_regs[wb_q[0].da] = val;
                    exp_q.push_back(val);
                end
                void'(wb_q.pop_front());
            end
            nx.rw = RW_EX; nx.da = int'(DA_EX); nx.md = int'(MD_EX);
            nx.f = F_EX; nx.nv = NxorV_EX;
            wb_q.push_back(nx);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        reset = 1'b1; RW_EX = 0; DA_EX = 0; MD_EX = 0; F_EX = 0; NxorV_EX = 0;
        DMEM_DATA = 0; AA = 0; BA = 0; use_A = 0; use_B = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset: outputs forced low even with a hazard-shaped EX instruction.
        drive(1, 1, 5, 0, 32'h1111, 0, 0, 5, 31, 1, 1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 5, 31, 1, 1);
        chk("rst_wb_data", WB_DATA, 32'd0);
        tick();

        // Bypass then array read of R3.
        drive(0, 1, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
        chk("bypass_r3", A_DATA, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
        chk("array_r3", A_DATA, 32'hDEADBEEF);
        tick();

        // Writes to R0 never stall and never become visible.
        drive(0, 1, 0, 0, 32'h1234, 0, 0, 0, 0, 1, 0);
        chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("r0_bypass", A_DATA, 32'd0);
        tick();

        // Hazard qualification by use_A / use_B / RW_EX.
        drive(0, 1, 7, 0, 32'h77, 0, 0, 7, 0, 1, 0);
        chk("haz_a", {31'd0, stall}, 32'd1);
        drive(0, 1, 7, 0, 32'h77, 0, 0, 7, 0, 0, 0);
        chk("haz_a_unused", {31'd0, stall}, 32'd0);
        drive(0, 1, 7, 0, 32'h77, 0, 0, 7, 7, 0, 1);
        chk("haz_b", {31'd0, stall}, 32'd1);
        drive(0, 0, 7, 0, 32'h77, 0, 0, 7, 7, 1, 1);
        chk("haz_no_rw", {31'd0, stall}, 32'd0);
        tick();

        // MD sources: memory to R9, set-less-than to R10, reserved to R11.
        drive(0, 1, 9, 1, 32'h0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 10, 2, 32'hFFFF_0000, 1, 32'hCAFEF00D, 9, 0, 1, 0);
        chk("md_mem_bypass", A_DATA, 32'hCAFEF00D);
        tick();
        drive(0, 1, 11, 3, 32'hFFFF, 0, 32'h0, 9, 10, 1, 1);
        chk("md_mem_array", A_DATA, 32'hCAFEF00D);
        chk("md_slt", B_DATA, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h5A5A5A5A, 11, 10, 1, 1);
        chk("md_rsvd", A_DATA, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 11, 10, 1, 1);
        tick();

        // Reset wins over a pending write; also clears earlier contents.
        drive(0, 1, 4, 0, 32'h55, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
        tick();
        drive(0, 1, 4, 0, 32'hAA, 0, 0, 4, 0, 1, 0);
        chk("r4_written", A_DATA, 32'h55);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 4, 4, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 4, 3, 1, 1);
        chk("r4_after_rst", A_DATA, 32'd0);
        chk("r3_after_rst", B_DATA, 32'd0);
        tick();

        // Randomized traffic; small address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, hi),
                  $urandom_range(0, 3),
                  $urandom(),
                  1'($urandom_range(0, 1)),
                  $urandom(),
                  $urandom_range(0, hi),
                  $urandom_range(0, hi),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick();
        end

        // Final sweep of the whole array against the model.
        for (int r = 0; r < 32; r++) begin
            drive(0, 0, 0, 0, 0, 0, 0, r, 31 - r, 1, 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
